// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the RV32I core. Walks each instruction through
// FETCH, DECODE, EXEC, MEM and WB and drives every datapath enable. It is the
// only block that writes the PC or the register file.
//
// Handshake: imem_req/dmem_req are held high while waiting. A ready input is
// honoured only in the state that waits on it (imem_ready in FETCH,
// dmem_ready in MEM); in every other state it is ignored. A request that sees
// no ready within TIMEOUT cycles parks the FSM in FAULT until rst.
module multicycle_control #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       branch_taken,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_req,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       alu_a_sel,
  output logic       alu_b_sel,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       reg_we,
  output logic [1:0] wb_sel,
  output logic [2:0] state_o,
  output logic       fault
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_FAULT  = 3'd5
  } state_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  // Counter value in the last permitted wait cycle.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       op_q, op_d;
  logic [2:0]       f3_q, f3_d;

  function automatic logic is_legal(input logic [6:0] opc);
    return (opc == OPC_OP)     || (opc == OPC_OP_IMM) || (opc == OPC_LOAD)  ||
           (opc == OPC_STORE)  || (opc == OPC_BRANCH) || (opc == OPC_JAL)   ||
           (opc == OPC_JALR)   || (opc == OPC_LUI)    || (opc == OPC_AUIPC) ||
           (opc == OPC_FENCE);
  endfunction

  // Next state, wait counter and opcode/funct3 capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    f3_d    = f3_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ready) begin
          state_d = S_DECODE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_FAULT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DECODE: begin
        // The decoder has settled from the IR; hold its fields for the
        // rest of the instruction.
        op_d    = opcode;
        f3_d    = funct3;
        state_d = is_legal(opcode) ? S_EXEC : S_FAULT;
        cnt_d   = '0;
      end
      S_EXEC: begin
        cnt_d = '0;
        case (op_q)
          OPC_BRANCH: state_d = (f3_q == 3'b010 || f3_q == 3'b011) ? S_FAULT : S_FETCH;
          OPC_FENCE:  state_d = S_FETCH;
          OPC_LOAD,
          OPC_STORE:  state_d = S_MEM;
          default:    state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (dmem_ready) begin
          state_d = (op_q == OPC_STORE) ? S_FETCH : S_WB;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_FAULT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        cnt_d   = '0;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
  end

  // State registers; reset returns to FETCH from anywhere.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      op_q    <= '0;
      f3_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      f3_q    <= f3_d;
    end
  end

  // Datapath enables decoded from state and the captured opcode; all 0 in reset.
  always_comb begin
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 2'd0;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    reg_we    = 1'b0;
    wb_sel    = 2'd0;
    state_o   = 3'd0;
    fault     = 1'b0;
    if (!rst) begin
      state_o = state_q;
      case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_we    = imem_ready;
        end
        S_EXEC: begin
          case (op_q)
            OPC_OP_IMM,
            OPC_LOAD,
            OPC_STORE,
            OPC_JALR:   alu_b_sel = 1'b1;
            OPC_AUIPC: begin
              alu_a_sel = 1'b1;
              alu_b_sel = 1'b1;
            end
            OPC_BRANCH: begin
              if (!(f3_q == 3'b010 || f3_q == 3'b011)) begin
                pc_we  = 1'b1;
                pc_src = {1'b0, branch_taken};
              end
            end
            OPC_FENCE:  pc_we = 1'b1;
            default: ;
          endcase
        end
        S_MEM: begin
          dmem_req  = 1'b1;
          dmem_we   = (op_q == OPC_STORE);
          alu_b_sel = 1'b1;
          pc_we     = dmem_ready && (op_q == OPC_STORE);
        end
        S_WB: begin
          reg_we = 1'b1;
          pc_we  = 1'b1;
          case (op_q)
            OPC_LOAD:  wb_sel = 2'd1;
            OPC_JAL:   begin wb_sel = 2'd2; pc_src = 2'd1; end
            OPC_JALR:  begin wb_sel = 2'd2; pc_src = 2'd2; end
            OPC_LUI:   wb_sel = 2'd3;
            default:   wb_sel = 2'd0;
          endcase
        end
        S_FAULT: fault = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control. Each instruction is expanded into a per-cycle
// script of input readies and expected outputs, then played back cycle by cycle.
module tb_multicycle_control;

  localparam int TO = 15;

  localparam logic [6:0] R_OP   = 7'b0110011;
  localparam logic [6:0] I_OP   = 7'b0010011;
  localparam logic [6:0] LD     = 7'b0000011;
  localparam logic [6:0] ST     = 7'b0100011;
  localparam logic [6:0] BR     = 7'b1100011;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] FENCE  = 7'b0001111;
  localparam logic [6:0] BADOP  = 7'b1111111;

  // ---------------- clock / reset / DUT ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       branch_taken, imem_ready, dmem_ready;
  logic       imem_req, ir_we, pc_we, alu_a_sel, alu_b_sel;
  logic       dmem_req, dmem_we, reg_we, fault;
  logic [1:0] pc_src, wb_sel;
  logic [2:0] state_o;

  always #5 clk = ~clk;

  multicycle_control #(.TIMEOUT(TO), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
    .branch_taken(branch_taken), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .reg_we(reg_we), .wb_sel(wb_sel), .state_o(state_o),
    .fault(fault)
  );

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];
  logic [1:0]  in_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  string       cur_tag;

  // Expected-vector layout:
  // {state, imem_req, ir_we, pc_we, pc_src, a_sel, b_sel, dreq, dwe, reg_we, wb_sel, fault}
  function automatic logic [15:0] mk(input logic [2:0] st, input logic ireq, input logic irw,
                                     input logic pcw, input logic [1:0] pcs, input logic a,
                                     input logic b, input logic dreq, input logic dwe,
                                     input logic rwe, input logic [1:0] wb, input logic flt);
    return {st, ireq, irw, pcw, pcs, a, b, dreq, dwe, rwe, wb, flt};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic add(input logic ir, input logic dr, input logic [15:0] e);
    in_q.push_back({ir, dr});
    exp_q.push_back(e);
  endtask

  task automatic add_fault_cycles();
    for (int i = 0; i < 3; i++) add(rb(), rb(), mk(3'd5,0,0,0,2'd0,0,0,0,0,0,2'd0,1));
  endtask

  // Reference: cycle-by-cycle expectation for one instruction. Returns 1 if it ends in FAULT.
  task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic bt,
                       input int iw, input int dw, output logic faulted);
    logic legal, is_ld, is_st, bad_br;
    logic [1:0] wb, pcs;
    faulted = 1'b0;
    legal  = op inside {R_OP, I_OP, LD, ST, BR, JAL, JALR, LUI, AUIPC, FENCE};
    is_ld  = (op == LD);
    is_st  = (op == ST);
    bad_br = (op == BR) && (f3 == 3'b010 || f3 == 3'b011);
    // fetch wait cycles, then the accepting cycle
    for (int i = 0; i < iw && i < TO; i++) add(1'b0, rb(), mk(3'd0,1,0,0,2'd0,0,0,0,0,0,2'd0,0));
    if (iw >= TO) begin add_fault_cycles(); faulted = 1'b1; return; end
    add(1'b1, rb(), mk(3'd0,1,1,0,2'd0,0,0,0,0,0,2'd0,0));
    // decode
    add(rb(), rb(), mk(3'd1,0,0,0,2'd0,0,0,0,0,0,2'd0,0));
    if (!legal || bad_br) begin
      if (bad_br) add(rb(), rb(), mk(3'd2,0,0,0,2'd0,0,0,0,0,0,2'd0,0));
      add_fault_cycles(); faulted = 1'b1; return;
    end
    // execute
    if (op == BR) begin
      add(rb(), rb(), mk(3'd2,0,0,1,bt ? 2'd1 : 2'd0,0,0,0,0,0,2'd0,0)); return;
    end
    if (op == FENCE) begin
      add(rb(), rb(), mk(3'd2,0,0,1,2'd0,0,0,0,0,0,2'd0,0)); return;
    end
    add(rb(), rb(), mk(3'd2,0,0,0,2'd0, op == AUIPC,
                       op inside {I_OP, LD, ST, JALR, AUIPC}, 0,0,0,2'd0,0));
    // memory
    if (is_ld || is_st) begin
      for (int i = 0; i < dw && i < TO; i++) add(rb(), 1'b0, mk(3'd3,0,0,0,2'd0,0,1,1,is_st,0,2'd0,0));
      if (dw >= TO) begin add_fault_cycles(); faulted = 1'b1; return; end
      add(rb(), 1'b1, mk(3'd3,0,0,is_st,2'd0,0,1,1,is_st,0,2'd0,0));
      if (is_st) return;
    end
    // writeback
    wb  = is_ld ? 2'd1 : (op == JAL || op == JALR) ? 2'd2 : (op == LUI) ? 2'd3 : 2'd0;
    pcs = (op == JAL) ? 2'd1 : (op == JALR) ? 2'd2 : 2'd0;
    add(rb(), rb(), mk(3'd4,0,0,1,pcs,0,0,0,0,1,wb,0));
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic ir, input logic dr, input logic [15:0] e);
    logic [15:0] obs;
    imem_ready = ir;
    dmem_ready = dr;
    @(negedge clk);
    obs = {state_o, imem_req, ir_we, pc_we, pc_src, alu_a_sel, alu_b_sel,
           dmem_req, dmem_we, reg_we, wb_sel, fault};
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", cur_tag, cyc, obs, e);
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic play(input int n);
    logic [1:0]  r;
    logic [15:0] e;
    for (int i = 0; i < n && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      r = in_q.pop_front();
      step(r[1], r[0], e);
    end
    exp_q.delete();
    in_q.delete();
  endtask

  task automatic do_reset();
    cur_tag = "reset";
    rst = 1'b1;
    step(rb(), rb(), 16'h0000);
    step(rb(), rb(), 16'h0000);
    rst = 1'b0;
  endtask

  task automatic run_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic bt, input int iw, input int dw);
    logic flt;
    cur_tag      = tag;
    opcode       = op;
    funct3       = f3;
    branch_taken = bt;
    build(op, f3, bt, iw, dw, flt);
    play(1000);
    if (flt) do_reset();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [6:0] ops[11];
    logic       flt;
    ops = '{R_OP, I_OP, LD, ST, BR, JAL, JALR, LUI, AUIPC, FENCE, BADOP};
    rst = 1'b1; opcode = '0; funct3 = '0; branch_taken = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0;
    @(posedge clk); #1;
    do_reset();

    run_instr("addi",      I_OP, 3'b000, 1'b0, 0, 0);
    run_instr("lw_wait3",  LD,   3'b010, 1'b0, 0, 3);
    run_instr("beq_t",     BR,   3'b000, 1'b1, 0, 0);
    run_instr("beq_nt",    BR,   3'b000, 1'b0, 0, 0);
    run_instr("jalr",      JALR, 3'b000, 1'b0, 0, 0);
    run_instr("jal",       JAL,  3'b000, 1'b0, 1, 0);
    run_instr("lui",       LUI,  3'b000, 1'b0, 0, 0);
    run_instr("auipc",     AUIPC,3'b000, 1'b0, 0, 0);
    run_instr("add",       R_OP, 3'b000, 1'b0, 2, 0);
    run_instr("fence",     FENCE,3'b000, 1'b0, 0, 0);
    run_instr("sw",        ST,   3'b010, 1'b0, 0, 0);
    run_instr("illegal",   BADOP,3'b000, 1'b0, 0, 0);
    run_instr("br_f3_010", BR,   3'b010, 1'b1, 0, 0);
    run_instr("fetch_late",I_OP, 3'b000, 1'b0, TO - 1, 0);
    run_instr("imem_to",   I_OP, 3'b000, 1'b0, TO, 0);
    run_instr("dmem_to",   ST,   3'b010, 1'b0, 0, TO);

    // reset mid-MEM wait: fetch, decode, exec, two MEM wait cycles, then rst
    cur_tag = "lw_midmem"; opcode = LD; funct3 = 3'b010;
    build(LD, 3'b010, 1'b0, 0, 10, flt);
    play(5);
    do_reset();
    run_instr("addi_after_rst", I_OP, 3'b000, 1'b0, 0, 0);

    // randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      run_instr("rand", ops[$urandom_range(0, 10)], 3'($urandom_range(0, 7)), rb(),
                $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle sequencer for the RV32I core.
- Steps each instruction through fetch, decode, execute, memory and writeback.
- Uses the opcode/funct3 fields produced by the instruction decoder and drives every datapath enable: IR load, PC update, register-file write, ALU operand muxes, data-memory request.
- Sits between the instruction/data memory handshakes and the decoder/ALU/register file. It is the only block that writes PC or the register file.

Parameters:
- TIMEOUT, 15: maximum cycles waiting on imem_ready or dmem_ready before entering FAULT.
- CNT_W, 4: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  7  decoder opcode field
- funct3  in  3  decoder funct3 field
- branch_taken  in  1  ALU compare result for the current branch
- imem_ready  in  1  instruction word valid this cycle
- dmem_ready  in  1  data access complete this cycle
- imem_req  out  1  instruction fetch request
- ir_we  out  1  latch instruction register
- pc_we  out  1  update PC this cycle
- pc_src  out  2  0 = PC+4, 1 = PC+imm, 2 = (rs1+imm) & ~1
- alu_a_sel  out  1  0 = rs1, 1 = PC
- alu_b_sel  out  1  0 = rs2, 1 = imm
- dmem_req  out  1  data memory request
- dmem_we  out  1  1 = store, valid with dmem_req
- reg_we  out  1  register-file write enable
- wb_sel  out  2  0 = ALU, 1 = load data, 2 = PC+4, 3 = imm
- state_o  out  3  current state, for debug
- fault  out  1  sticky fault flag

Behaviour:
- State encoding: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, FAULT = 5.
- Reset:
  - rst sampled high moves the FSM to FETCH at the next edge, clears the wait counter and clears fault.
  - Applies from any state, including mid-wait in FETCH or MEM.
  - While rst is high, all outputs are 0.
  - The first cycle after rst is released, imem_req = 1.
- Outputs are combinational from state and registered opcode/funct3 (Moore plus opcode qualification). Unlisted outputs are 0.
- FETCH:
  - imem_req = 1.
  - When imem_ready = 1: ir_we = 1 in the same cycle, go to DECODE, clear the counter.
  - Otherwise increment the counter. Reaching TIMEOUT goes to FAULT.
- DECODE:
  - Single cycle; the decoder settles from the IR.
  - Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 0001111.
  - Legal opcode goes to EXEC; anything else goes to FAULT.
- EXEC:
  - OP: alu_b_sel = 0, then WB.
  - OP-IMM, LOAD, STORE, JALR: alu_b_sel = 1. LOAD/STORE go to MEM; the others go to WB.
  - AUIPC: alu_a_sel = 1, alu_b_sel = 1, then WB. LUI goes to WB.
  - BRANCH: pc_we = 1, pc_src = branch_taken ? 1 : 0, then FETCH.
  - BRANCH with funct3 = 010 or 011 goes to FAULT, with pc_we = 0.
  - JAL: WB.
  - FENCE: pc_we = 1, pc_src = 0, then FETCH (treated as a NOP).
- MEM:
  - dmem_req = 1, with dmem_we = 1 for STORE. alu_b_sel stays 1 so the address is held.
  - Wait on dmem_ready with the same counter and timeout rule as FETCH.
  - On ready, STORE: pc_we = 1, pc_src = 0, then FETCH.
  - On ready, LOAD: go to WB.
- WB:
  - reg_we = 1 and pc_we = 1, then FETCH.
  - wb_sel: 1 for LOAD, 2 for JAL/JALR, 3 for LUI, 0 otherwise.
  - pc_src: 1 for JAL, 2 for JALR, 0 otherwise.
- FAULT:
  - fault = 1, all enables 0. Left only by rst.
- Latency with zero-wait memory (ready in the first request cycle):
  - R/I/LUI/AUIPC/JAL/JALR: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH and FENCE: 3 cycles.
  - Each wait cycle adds 1.
- Invariants:
  - pc_we and reg_we each pulse at most once per instruction.
  - reg_we never asserts for STORE, BRANCH or FENCE.
  - ir_we is only asserted in FETCH.
  - A late or spurious ready is ignored in any state other than the one waiting on it.

Test Plan:
- Reset: rst high for 2 cycles mid-MEM wait -> state_o = 0, fault = 0, all outputs 0; imem_req = 1 the cycle after release.
- ADDI (opcode 0010011), zero-wait memory -> states 0, 1, 2, 4. ir_we in cycle 0. alu_b_sel = 1 in EXEC. reg_we = 1, pc_we = 1, wb_sel = 0 in cycle 3.
- LW with dmem_ready delayed 3 cycles -> MEM held 4 cycles with dmem_req = 1, dmem_we = 0. Then WB with wb_sel = 1; total 8 cycles.
- BEQ with branch_taken = 1, then with branch_taken = 0 -> pc_we in EXEC with pc_src = 1 and 0 respectively, reg_we = 0 throughout; back to FETCH after 3 cycles.
- JALR -> WB with reg_we = 1, wb_sel = 2, pc_src = 2.
- Illegal opcode 1111111 -> FAULT after DECODE with fault = 1 held.
- imem_ready held 0 -> FAULT after exactly TIMEOUT = 15 wait cycles.
- SW with dmem_ready = 1 immediately -> dmem_req = 1, dmem_we = 1 for 1 cycle, then pc_we = 1, pc_src = 0, reg_we never 1.
